// File: rtl/alu_uart_interface_pkg.sv
// Shared definitions for the ALU/UART sequencer: FSM state encoding,
// default widths and the ALU opcode map used by the design and benches.
package alu_if_pkg;

  localparam int unsigned NB_DATA_DEF = 8;
  localparam int unsigned NB_OP_DEF   = 6;

  typedef enum logic [2:0] {
    WAIT_A  = 3'd0,
    WAIT_B  = 3'd1,
    WAIT_OP = 3'd2,
    SEND    = 3'd3,
    WAIT_TX = 3'd4
  } state_e;

  localparam logic [NB_OP_DEF-1:0] OP_ADD = 6'h20;
  localparam logic [NB_OP_DEF-1:0] OP_SUB = 6'h22;
  localparam logic [NB_OP_DEF-1:0] OP_AND = 6'h24;
  localparam logic [NB_OP_DEF-1:0] OP_OR  = 6'h25;
  localparam logic [NB_OP_DEF-1:0] OP_XOR = 6'h26;
  localparam logic [NB_OP_DEF-1:0] OP_NOR = 6'h27;
  localparam logic [NB_OP_DEF-1:0] OP_SRA = 6'h03;
  localparam logic [NB_OP_DEF-1:0] OP_SRL = 6'h02;

endpackage

// File: rtl/alu_uart_interface_if.sv
// Bundle of UART RX/TX, ALU operand/result and status signals seen by the
// sequencer. slave = the sequencer itself, master = its surroundings.
interface alu_uart_interface_if
  import alu_if_pkg::*;
#(
  parameter int unsigned NB_DATA = NB_DATA_DEF,
  parameter int unsigned NB_OP   = NB_OP_DEF
);
  logic [NB_DATA-1:0] i_rx_data;
  logic               i_rx_done;
  logic [NB_DATA-1:0] o_data_a;
  logic [NB_DATA-1:0] o_data_b;
  logic [NB_OP-1:0]   o_operation;
  logic [NB_DATA-1:0] i_alu_result;
  logic [NB_DATA-1:0] o_tx_data;
  logic               o_tx_start;
  logic               i_tx_done;
  logic               o_busy;
  logic               o_overrun;

  modport slave (
    input  i_rx_data, i_rx_done, i_alu_result, i_tx_done,
    output o_data_a, o_data_b, o_operation, o_tx_data, o_tx_start,
           o_busy, o_overrun
  );

  modport master (
    output i_rx_data, i_rx_done, i_alu_result, i_tx_done,
    input  o_data_a, o_data_b, o_operation, o_tx_data, o_tx_start,
           o_busy, o_overrun
  );
endinterface

// File: rtl/alu_uart_interface.sv
// Collects operand A, operand B and opcode as three UART bytes, drives them
// to the ALU, then hands the ALU result to the UART transmitter.
// Optional macro ALU_IF_OVERRUN_EN builds the sticky dropped-byte flag.
module alu_uart_interface
  import alu_if_pkg::*;
#(
  parameter int unsigned NB_DATA = NB_DATA_DEF,
  parameter int unsigned NB_OP   = NB_OP_DEF
)(
  input logic                 i_clk,
  input logic                 i_rst_n,
  alu_uart_interface_if.slave bus
);

  state_e             state_q, state_d;
  logic [NB_DATA-1:0] data_a_q, data_a_d;
  logic [NB_DATA-1:0] data_b_q, data_b_d;
  logic [NB_OP-1:0]   op_q, op_d;
  logic [NB_DATA-1:0] tx_data_q, tx_data_d;
  logic               tx_start_q, tx_start_d;
  logic               busy_q, busy_d;

  // Next-state and next-register computation for the byte sequencer
  always_comb begin
    state_d    = state_q;
    data_a_d   = data_a_q;
    data_b_d   = data_b_q;
    op_d       = op_q;
    tx_data_d  = tx_data_q;
    tx_start_d = 1'b0;
    case (state_q)
      WAIT_A: if (bus.i_rx_done) begin
        data_a_d = bus.i_rx_data;
        state_d  = WAIT_B;
      end
      WAIT_B: if (bus.i_rx_done) begin
        data_b_d = bus.i_rx_data;
        state_d  = WAIT_OP;
      end
      WAIT_OP: if (bus.i_rx_done) begin
        op_d    = bus.i_rx_data[NB_OP-1:0];
        state_d = SEND;
      end
      SEND: begin
        tx_data_d  = bus.i_alu_result;
        tx_start_d = 1'b1;
        state_d    = WAIT_TX;
      end
      WAIT_TX: begin
        // The first WAIT_TX cycle is the one carrying the start pulse; a done
        // strobe there cannot belong to this byte and is ignored.
        if (bus.i_tx_done && !tx_start_q) state_d = WAIT_A;
      end
      default: state_d = WAIT_A;
    endcase
    busy_d = (state_d == SEND) || (state_d == WAIT_TX);
  end

  // State and datapath registers
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q    <= WAIT_A;
      data_a_q   <= '0;
      data_b_q   <= '0;
      op_q       <= '0;
      tx_data_q  <= '0;
      tx_start_q <= 1'b0;
      busy_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      data_a_q   <= data_a_d;
      data_b_q   <= data_b_d;
      op_q       <= op_d;
      tx_data_q  <= tx_data_d;
      tx_start_q <= tx_start_d;
      busy_q     <= busy_d;
    end
  end

  assign bus.o_data_a    = data_a_q;
  assign bus.o_data_b    = data_b_q;
  assign bus.o_operation = op_q;
  assign bus.o_tx_data   = tx_data_q;
  assign bus.o_tx_start  = tx_start_q;
  assign bus.o_busy      = busy_q;

`ifdef ALU_IF_OVERRUN_EN
  logic rx_drop;
  logic overrun_q, overrun_d;

  // A strobe arriving while busy is dropped and latched as overrun
  always_comb begin
    rx_drop   = bus.i_rx_done && ((state_q == SEND) || (state_q == WAIT_TX));
    overrun_d = overrun_q | rx_drop;
  end

  // Sticky overrun flag, cleared only by reset
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) overrun_q <= 1'b0;
    else          overrun_q <= overrun_d;
  end

  assign bus.o_overrun = overrun_q;
`else
  assign bus.o_overrun = 1'b0;
`endif

endmodule

// File: tb/tb_alu_uart_interface.sv
// Self-checking bench for alu_uart_interface: directed vector table, corner
// sequences (drop, early done, mid-transaction reset, back-to-back) and
// randomized transactions against a byte-level reference model.
module tb_alu_uart_interface;
  import alu_if_pkg::*;

`ifdef ALU_IF_OVERRUN_EN
  localparam bit OVR_EN = 1'b1;
`else
  localparam bit OVR_EN = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  alu_uart_interface_if #(.NB_DATA(8), .NB_OP(6)) bus ();

  alu_uart_interface #(.NB_DATA(8), .NB_OP(6)) dut (
    .i_clk   (clk),
    .i_rst_n (rst_n),
    .bus     (bus)
  );

  int checks = 0;
  int errors = 0;
  logic exp_ovr = 1'b0;

  // Behavioural ALU as defined by the opcode map
  function automatic logic [7:0] alu_model(input logic [7:0] a, input logic [7:0] b,
                                           input logic [5:0] op);
    logic [7:0] r;
    case (op)
      OP_ADD:  r = a + b;
      OP_SUB:  r = a - b;
      OP_AND:  r = a & b;
      OP_OR:   r = a | b;
      OP_XOR:  r = a ^ b;
      OP_NOR:  r = ~(a | b);
      OP_SRA:  r = 8'($signed(a) >>> b);
      OP_SRL:  r = a >> b;
      default: r = '0;
    endcase
    return r;
  endfunction

  always_comb bus.i_alu_result = alu_model(bus.o_data_a, bus.o_data_b, bus.o_operation);

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send_byte(input logic [7:0] b);
    bus.i_rx_data = b;
    bus.i_rx_done = 1'b1;
    tick();
    bus.i_rx_done = 1'b0;
  endtask

  // Idle cycles between bytes; optional stray tx_done pulses must be ignored
  task automatic idle(input int unsigned n, input bit noise);
    for (int unsigned i = 0; i < n; i++) begin
      bus.i_tx_done = noise && ($urandom_range(0, 1) == 1);
      tick();
    end
    bus.i_tx_done = 1'b0;
  endtask

  // Three bytes in, then check the start pulse timing and result hand-off.
  // Returns with the DUT in WAIT_TX, one cycle after the start pulse.
  task automatic run_txn(input logic [7:0] a, input logic [7:0] b, input logic [7:0] opb,
                         input logic [7:0] res, input bit done_with_start, input int unsigned gap);
    logic [5:0] op;
    op = opb[5:0];
    send_byte(a);
    idle(gap, 1'b1);
    send_byte(b);
    idle(gap, 1'b1);
    send_byte(opb);
    chk("start_not_early", bus.o_tx_start, 0);
    tick();
    chk("tx_start_pulse", bus.o_tx_start, 1);
    chk("tx_data", bus.o_tx_data, res);
    chk("data_a", bus.o_data_a, a);
    chk("data_b", bus.o_data_b, b);
    chk("operation", bus.o_operation, op);
    chk("busy_wait_tx", bus.o_busy, 1);
    if (done_with_start) bus.i_tx_done = 1'b1;
    tick();
    bus.i_tx_done = 1'b0;
    chk("tx_start_one_cycle", bus.o_tx_start, 0);
    chk("tx_data_held", bus.o_tx_data, res);
    chk("busy_held", bus.o_busy, 1);
  endtask

  task automatic finish_txn();
    bus.i_tx_done = 1'b1;
    tick();
    bus.i_tx_done = 1'b0;
    chk("busy_after_done", bus.o_busy, 0);
    chk("overrun", bus.o_overrun, exp_ovr);
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_a"}, bus.o_data_a, 0);
    chk({tag, "_b"}, bus.o_data_b, 0);
    chk({tag, "_op"}, bus.o_operation, 0);
    chk({tag, "_txd"}, bus.o_tx_data, 0);
    chk({tag, "_start"}, bus.o_tx_start, 0);
    chk({tag, "_busy"}, bus.o_busy, 0);
    chk({tag, "_ovr"}, bus.o_overrun, 0);
  endtask

  typedef struct {
    logic [7:0] a;
    logic [7:0] b;
    logic [7:0] opb;
    logic [7:0] res;
  } vec_t;

  vec_t vecs[9];
  logic [5:0] ops[8];

  initial begin
    vecs[0] = '{8'h05, 8'h03, 8'h20, 8'h08};
    vecs[1] = '{8'h81, 8'h01, 8'hE2, 8'h80};
    vecs[2] = '{8'h0F, 8'hF0, 8'h25, 8'hFF};
    vecs[3] = '{8'hF0, 8'h3C, 8'h24, 8'h30};
    vecs[4] = '{8'hAA, 8'h55, 8'h26, 8'hFF};
    vecs[5] = '{8'h00, 8'h00, 8'h27, 8'hFF};
    vecs[6] = '{8'h80, 8'h01, 8'h03, 8'hC0};
    vecs[7] = '{8'h80, 8'h03, 8'h02, 8'h10};
    vecs[8] = '{8'hFF, 8'h01, 8'h60, 8'h00};
    ops = '{OP_ADD, OP_SUB, OP_AND, OP_OR, OP_XOR, OP_NOR, OP_SRA, OP_SRL};

    bus.i_rx_data = '0;
    bus.i_rx_done = 1'b0;
    bus.i_tx_done = 1'b0;

    // Reset state
    tick();
    tick();
    chk_all_zero("reset");
    rst_n = 1'b1;
    tick();
    chk_all_zero("post_reset");

    // Directed vector table
    for (int i = 0; i < 9; i++) begin
      run_txn(vecs[i].a, vecs[i].b, vecs[i].opb, vecs[i].res, 1'b0, 0);
      idle(2, 1'b0);
      finish_txn();
      idle(1, 1'b1);
    end

    // Byte strobed during WAIT_TX is dropped
    run_txn(8'h12, 8'h34, 8'h20, 8'h46, 1'b0, 1);
    send_byte(8'h77);
    chk("drop_keeps_a", bus.o_data_a, 8'h12);
    if (OVR_EN) exp_ovr = 1'b1;
    chk("overrun_on_drop", bus.o_overrun, exp_ovr);
    finish_txn();
    run_txn(8'h09, 8'h02, 8'h22, 8'h07, 1'b0, 0);
    finish_txn();

    // tx_done coincident with start pulse is ignored; WAIT_TX holds
    run_txn(8'h20, 8'h10, 8'h27, 8'hCF, 1'b1, 0);
    idle(5, 1'b0);
    chk("hold_wait_tx", bus.o_busy, 1);
    finish_txn();
    run_txn(8'h0F, 8'hF0, 8'h25, 8'hFF, 1'b0, 0);
    finish_txn();

    // rx_done together with tx_done in WAIT_TX: return to WAIT_A, byte dropped
    run_txn(8'h44, 8'h11, 8'h26, 8'h55, 1'b0, 0);
    bus.i_rx_data = 8'hEE;
    bus.i_rx_done = 1'b1;
    finish_txn();
    bus.i_rx_done = 1'b0;
    chk("coincident_drop_a", bus.o_data_a, 8'h44);
    if (OVR_EN) exp_ovr = 1'b1;
    run_txn(8'h01, 8'h02, 8'h20, 8'h03, 1'b0, 0);
    finish_txn();

    // Asynchronous reset in WAIT_OP
    send_byte(8'h11);
    send_byte(8'h22);
    rst_n = 1'b0;
    #2;
    chk_all_zero("async_reset");
    exp_ovr = 1'b0;
    tick();
    rst_n = 1'b1;
    tick();
    run_txn(8'h03, 8'h04, 8'h20, 8'h07, 1'b0, 0);
    finish_txn();

    // Back-to-back: next A strobed the cycle after tx_done
    run_txn(8'h10, 8'h20, 8'h20, 8'h30, 1'b0, 0);
    finish_txn();
    run_txn(8'h50, 8'h05, 8'h22, 8'h4B, 1'b0, 0);
    finish_txn();
    chk("b2b_no_overrun", bus.o_overrun, 0);

    // Randomized transactions against the reference model
    for (int n = 0; n < 30; n++) begin
      logic [7:0] a, b, opb;
      logic [5:0] op;
      logic [1:0] hi;
      a   = 8'($urandom);
      b   = 8'($urandom);
      op  = ops[$urandom_range(0, 7)];
      hi  = 2'($urandom_range(0, 3));
      opb = {hi, op};
      run_txn(a, b, opb, alu_model(a, b, op), 1'($urandom_range(0, 1)),
              $urandom_range(0, 2));
      idle($urandom_range(0, 3), 1'b0);
      finish_txn();
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
